// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
package mdu_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;

   // True for the ops that occupy the unit for a multi-cycle busy period.
   function automatic logic is_md_arith(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-stage bundle between the decoder/hazard logic and the MD unit.
interface mdu_ctrl_if;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        busy;
   logic        md_stall;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, md_op, rs_val, rt_val,
                   input  busy, md_stall, hi, lo);
   modport slave  (input  start, md_op, rs_val, rt_val,
                   output busy, md_stall, hi, lo);
endinterface

// File: rtl/mdu_core.sv
// Combinational multiply/divide datapath; result is {hi, lo}.
module mdu_core
   import mdu_pkg::*;
(
   input  md_op_e       i_op,
   input  logic [31:0]  i_rs,
   input  logic [31:0]  i_rt,
   output logic [63:0]  o_result,
   output logic         o_div_zero
);

   logic signed [63:0] w_rs_s;
   logic signed [63:0] w_rt_s;
   logic signed [63:0] w_rt_safe_s;
   logic        [63:0] w_rs_u;
   logic        [63:0] w_rt_u;
   logic        [63:0] w_rt_safe_u;
   logic signed [63:0] w_quo_s;
   logic signed [63:0] w_rem_s;
   logic        [63:0] w_quo_u;
   logic        [63:0] w_rem_u;
   logic               w_rt_zero;

   assign w_rs_s    = {{32{i_rs[31]}}, i_rs};
   assign w_rt_s    = {{32{i_rt[31]}}, i_rt};
   assign w_rs_u    = {32'd0, i_rs};
   assign w_rt_u    = {32'd0, i_rt};
   assign w_rt_zero = (i_rt == 32'd0);

   // Divisor forced to 1 on zero so the datapath never sees x/0; the result is discarded anyway.
   assign w_rt_safe_s = w_rt_zero ? 64'sd1 : w_rt_s;
   assign w_rt_safe_u = w_rt_zero ? 64'd1  : w_rt_u;

   assign w_quo_s = w_rs_s / w_rt_safe_s;
   assign w_rem_s = w_rs_s % w_rt_safe_s;
   assign w_quo_u = w_rs_u / w_rt_safe_u;
   assign w_rem_u = w_rs_u % w_rt_safe_u;

   assign o_div_zero = w_rt_zero && ((i_op == MD_DIV) || (i_op == MD_DIVU));

   always_comb begin
      o_result = 64'd0;
      case (i_op)
         MD_MULT:  o_result = w_rs_s * w_rt_s;
         MD_MULTU: o_result = w_rs_u * w_rt_u;
         MD_DIV:   o_result = {w_rem_s[31:0], w_quo_s[31:0]};
         MD_DIVU:  o_result = {w_rem_u[31:0], w_quo_u[31:0]};
         default:  o_result = 64'd0;
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// MD unit controller: operand latches, fixed-latency countdown and HI/LO registers.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)(
   input  logic       clk,
   input  logic       reset,
   mdu_ctrl_if.slave  bus
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   typedef enum logic {S_IDLE, S_RUN} state_e;

   state_e      r_state, w_state_next;
   logic [CW-1:0] r_cnt, w_cnt_next;
   md_op_e      r_op, w_op_next;
   logic [31:0] r_rs, w_rs_next;
   logic [31:0] r_rt, w_rt_next;
   logic [31:0] r_hi, w_hi_next;
   logic [31:0] r_lo, w_lo_next;

   logic [63:0] w_result;
   logic        w_div_zero;
   logic        w_start_arith;

   mdu_core u_core (
      .i_op       (r_op),
      .i_rs       (r_rs),
      .i_rt       (r_rt),
      .o_result   (w_result),
      .o_div_zero (w_div_zero)
   );

   assign w_start_arith = bus.start && is_md_arith(bus.md_op);

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_op_next    = r_op;
      w_rs_next    = r_rs;
      w_rt_next    = r_rt;
      w_hi_next    = r_hi;
      w_lo_next    = r_lo;
      case (r_state)
         S_IDLE: begin
            if (w_start_arith) begin
               w_op_next    = md_op_e'(bus.md_op);
               w_rs_next    = bus.rs_val;
               w_rt_next    = bus.rt_val;
               w_state_next = S_RUN;
               if ((bus.md_op == MD_MULT) || (bus.md_op == MD_MULTU))
                  w_cnt_next = CW'(MULT_CYCLES);
               else
                  w_cnt_next = CW'(DIV_CYCLES);
            end else if (bus.start && (bus.md_op == MD_MTHI)) begin
               w_hi_next = bus.rs_val;
            end else if (bus.start && (bus.md_op == MD_MTLO)) begin
               w_lo_next = bus.rs_val;
            end
         end
         S_RUN: begin
            // Any start seen here is dropped: HI/LO only change on commit.
            if (r_cnt == CW'(1)) begin
               w_state_next = S_IDLE;
               w_cnt_next   = '0;
               if (!w_div_zero) begin
                  w_hi_next = w_result[63:32];
                  w_lo_next = w_result[31:0];
               end
            end else begin
               w_cnt_next = r_cnt - CW'(1);
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_op    <= MD_NONE;
         r_rs    <= 32'd0;
         r_rt    <= 32'd0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_op    <= w_op_next;
         r_rs    <= w_rs_next;
         r_rt    <= w_rt_next;
         r_hi    <= w_hi_next;
         r_lo    <= w_lo_next;
      end
   end

   assign bus.busy     = (r_state == S_RUN);
   assign bus.md_stall = (r_state == S_RUN) || w_start_arith;
   assign bus.hi       = r_hi;
   assign bus.lo       = r_lo;

endmodule
